// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer: opcode map, FSM state encoding and default sizes.
package alu_pkg;

    localparam int WORD_SIZE_DFLT   = 32;
    localparam int OPCODE_W_DFLT    = 5;
    localparam int MULDIV_WAIT_DFLT = 2;

    localparam int OP_NOP = 0;
    localparam int OP_ADD = 1;
    localparam int OP_SUB = 2;
    localparam int OP_MUL = 3;
    localparam int OP_DIV = 4;
    localparam int OP_SHR = 5;
    localparam int OP_SHL = 6;
    localparam int OP_ROR = 7;
    localparam int OP_ROL = 8;
    localparam int OP_AND = 9;
    localparam int OP_OR  = 10;
    localparam int OP_XOR = 11;
    localparam int OP_NOR = 12;
    localparam int OP_SLT = 13;
    localparam int OP_NEG = 14;
    localparam int OP_NOT = 15;
    localparam int OP_MAX = 15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_EXEC = 2'd2,
        ST_RESP = 2'd3
    } state_e;

endpackage

// File: rtl/alu_seq_ctrl.sv
// Request/response sequencer in front of a registered ALU: issue, hold, capture, return.
// Optional divide-by-zero short-circuit enabled by defining ALU_SEQ_DIVZERO_CHK_EN.
module alu_seq_ctrl
    import alu_pkg::*;
#(
    parameter int WORD_SIZE   = WORD_SIZE_DFLT,
    parameter int OPCODE_W    = OPCODE_W_DFLT,
    parameter int MULDIV_WAIT = MULDIV_WAIT_DFLT
) (
    input  logic                   clk,
    input  logic                   clr,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [OPCODE_W-1:0]    req_opcode,
    input  logic [WORD_SIZE-1:0]   req_a,
    input  logic [WORD_SIZE-1:0]   req_b,
    output logic [WORD_SIZE-1:0]   alu_y,
    output logic [WORD_SIZE-1:0]   alu_b,
    output logic [OPCODE_W-1:0]    alu_opcode,
    input  logic [2*WORD_SIZE-1:0] alu_c,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [WORD_SIZE-1:0]   rsp_lo,
    output logic [WORD_SIZE-1:0]   rsp_hi,
    output logic                   rsp_err,
    output logic                   busy
);

    localparam int CNT_W = (MULDIV_WAIT < 1) ? 1 : $clog2(MULDIV_WAIT + 1);

    state_e              state, state_nxt;
    logic [OPCODE_W-1:0] op_q;
    logic [CNT_W-1:0]    cnt;
    logic                accept;
    logic                req_legal;
    logic                req_divz;
    logic                issue;
    logic                op_muldiv;
    logic                exec_done;

    assign accept    = req_valid && req_ready;
    assign req_legal = (req_opcode != '0) && (req_opcode <= OPCODE_W'(OP_MAX));

`ifdef ALU_SEQ_DIVZERO_CHK_EN
    assign req_divz  = (req_opcode == OPCODE_W'(OP_DIV)) && (req_b == '0);
`else
    assign req_divz  = 1'b0;
`endif

    // Anything not issued to the ALU is answered directly with an error response.
    assign issue     = req_legal && !req_divz;
    assign op_muldiv = (op_q == OPCODE_W'(OP_MUL)) || (op_q == OPCODE_W'(OP_DIV));
    assign exec_done = (state == ST_EXEC) && (cnt == '0);

    assign req_ready  = (state == ST_IDLE) && clr;
    assign rsp_valid  = (state == ST_RESP);
    assign busy       = (state != ST_IDLE);
    assign alu_opcode = ((state == ST_LOAD) || (state == ST_EXEC)) ? op_q : '0;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: default assigned first so no path through the case leaves state_nxt unassigned (no latch).
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = issue ? ST_LOAD : ST_RESP;
            ST_LOAD: state_nxt = ST_EXEC;
            ST_EXEC: if (cnt == '0) state_nxt = ST_RESP;
            ST_RESP: if (rsp_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // ALU operand registers only load on issue, so they never toggle for rejected requests.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            op_q    <= '0;
            alu_y   <= '0;
            alu_b   <= '0;
            cnt     <= '0;
            rsp_lo  <= '0;
            rsp_hi  <= '0;
            rsp_err <= 1'b0;
        end else begin
            if (accept) begin
                op_q <= req_opcode;
                if (issue) begin
                    alu_y <= req_a;
                    alu_b <= req_b;
                end else begin
                    rsp_lo  <= '0;
                    rsp_hi  <= '0;
                    rsp_err <= 1'b1;
                end
            end

            if (state == ST_LOAD) begin
                cnt <= op_muldiv ? CNT_W'(MULDIV_WAIT) : '0;
            end else if ((state == ST_EXEC) && (cnt != '0)) begin
                cnt <= cnt - 1'b1;
            end

            if (exec_done) begin
                rsp_lo  <= alu_c[WORD_SIZE-1:0];
                rsp_hi  <= alu_c[2*WORD_SIZE-1:WORD_SIZE];
                rsp_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed self-checking bench for alu_seq_ctrl with a small registered ALU model on alu_c.
// Covers both builds of ALU_SEQ_DIVZERO_CHK_EN.
module tb_alu_seq_ctrl;

    logic        clk;
    logic        clr;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_opcode;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [31:0] alu_y;
    logic [31:0] alu_b;
    logic [4:0]  alu_opcode;
    logic [63:0] alu_c;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_lo;
    logic [31:0] rsp_hi;
    logic        rsp_err;
    logic        busy;

    int tests = 0;
    int fails = 0;

    alu_seq_ctrl #(.WORD_SIZE(32), .OPCODE_W(5), .MULDIV_WAIT(2)) dut (
        .clk(clk), .clr(clr),
        .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
        .req_a(req_a), .req_b(req_b),
        .alu_y(alu_y), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_c(alu_c),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_lo(rsp_lo), .rsp_hi(rsp_hi), .rsp_err(rsp_err), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered ALU stand-in: C follows the inputs one edge later; NOP yields 0.
    function automatic logic [63:0] alu_f(input logic [4:0] op, input logic [31:0] y, input logic [31:0] b);
        case (op)
            5'd1:    alu_f = {32'h0, y + b};
            5'd3:    alu_f = 64'(y) * 64'(b);
            5'd4:    alu_f = (b == 32'h0) ? {y, 32'hFFFF_FFFF} : {y % b, y / b};
            5'd6:    alu_f = {32'h0, y << b[4:0]};
            default: alu_f = 64'h0;
        endcase
    endfunction

    always @(posedge clk) alu_c <= alu_f(alu_opcode, alu_y, alu_b);

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a request, waits (bounded) for acceptance, returns one cycle after the accept edge.
    task automatic send(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        int n;
        n = 0;
        req_valid  = 1'b1;
        req_opcode = op;
        req_a      = a;
        req_b      = b;
        while (!req_ready && n < 20) begin
            tick();
            n++;
        end
        check("req_ready_wait", req_ready, 1);
        tick();
        req_valid  = 1'b0;
        req_opcode = 5'd0;
    endtask

    task automatic finish_rsp();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("idle_busy", busy, 0);
        check("idle_req_ready", req_ready, 1);
        check("idle_rsp_valid", rsp_valid, 0);
    endtask

    initial begin
        clr        = 1'b0;
        req_valid  = 1'b0;
        req_opcode = 5'd0;
        req_a      = 32'h0;
        req_b      = 32'h0;
        rsp_ready  = 1'b0;

        // Reset state
        #2;
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_alu_opcode", alu_opcode, 0);
        check("rst_alu_y", alu_y, 0);
        check("rst_rsp_lo", rsp_lo, 0);
        check("rst_rsp_err", rsp_err, 0);
        tick();
        tick();
        clr = 1'b1;
        #1;
        check("rel_req_ready", req_ready, 1);

        // 1. add 5+7: LOAD, EXEC, then RESP on cycle 3
        send(5'd1, 32'd5, 32'd7);
        check("add_c1_opcode", alu_opcode, 1);
        check("add_c1_valid", rsp_valid, 0);
        check("add_c1_ready", req_ready, 0);
        check("add_c1_y", alu_y, 5);
        check("add_c1_b", alu_b, 7);
        tick();
        check("add_c2_opcode", alu_opcode, 1);
        check("add_c2_valid", rsp_valid, 0);
        tick();
        check("add_c3_valid", rsp_valid, 1);
        check("add_c3_opcode", alu_opcode, 0);
        check("add_lo", rsp_lo, 12);
        check("add_hi", rsp_hi, 0);
        check("add_err", rsp_err, 0);
        finish_rsp();

        // 2. mul 0x10000*0x10000: RESP on cycle 5, inputs held
        send(5'd3, 32'h0001_0000, 32'h0001_0000);
        for (int i = 1; i <= 4; i++) begin
            check("mul_opcode", alu_opcode, 3);
            check("mul_y", alu_y, 32'h0001_0000);
            check("mul_b", alu_b, 32'h0001_0000);
            check("mul_valid_low", rsp_valid, 0);
            tick();
        end
        check("mul_valid", rsp_valid, 1);
        check("mul_hi", rsp_hi, 1);
        check("mul_lo", rsp_lo, 0);
        check("mul_err", rsp_err, 0);
        finish_rsp();

        // 3. illegal opcode 16: error response after one cycle, ALU untouched
        send(5'd16, 32'hDEAD_BEEF, 32'h1234_5678);
        check("ill_valid", rsp_valid, 1);
        check("ill_err", rsp_err, 1);
        check("ill_lo", rsp_lo, 0);
        check("ill_hi", rsp_hi, 0);
        check("ill_opcode", alu_opcode, 0);
        check("ill_y_kept", alu_y, 32'h0001_0000);
        finish_rsp();

        // 4. shl 1<<4 with a stalled consumer
        send(5'd6, 32'd1, 32'd4);
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            check("shl_valid", rsp_valid, 1);
            check("shl_lo", rsp_lo, 16);
            check("shl_req_ready", req_ready, 0);
            check("shl_busy", busy, 1);
            tick();
        end
        finish_rsp();

        // div 100/7 completes normally
        send(5'd4, 32'd100, 32'd7);
        for (int i = 1; i <= 4; i++) tick();
        check("div_valid", rsp_valid, 1);
        check("div_lo", rsp_lo, 14);
        check("div_hi", rsp_hi, 2);
        finish_rsp();

        // 5. reset during EXEC of div aborts it
        send(5'd4, 32'd50, 32'd3);
        tick();
        check("abort_in_exec", alu_opcode, 4);
        clr = 1'b0;
        #1;
        check("abort_valid", rsp_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_req_ready", req_ready, 0);
        check("abort_opcode", alu_opcode, 0);
        check("abort_y", alu_y, 0);
        check("abort_b", alu_b, 0);
        check("abort_lo", rsp_lo, 0);
        tick();
        clr = 1'b1;
        #1;
        check("abort_rel_ready", req_ready, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("abort_no_rsp", rsp_valid, 0);
        end
        send(5'd1, 32'd20, 32'd22);
        tick();
        tick();
        check("post_abort_valid", rsp_valid, 1);
        check("post_abort_lo", rsp_lo, 42);
        finish_rsp();

        // 6. divide by zero
        send(5'd4, 32'd9, 32'd0);
`ifdef ALU_SEQ_DIVZERO_CHK_EN
        check("dz_valid", rsp_valid, 1);
        check("dz_err", rsp_err, 1);
        check("dz_lo", rsp_lo, 0);
        check("dz_hi", rsp_hi, 0);
        check("dz_opcode", alu_opcode, 0);
        check("dz_y_kept", alu_y, 20);
`else
        check("dz_opcode", alu_opcode, 4);
        for (int i = 1; i <= 4; i++) tick();
        check("dz_valid", rsp_valid, 1);
        check("dz_err", rsp_err, 0);
        check("dz_lo", rsp_lo, 32'hFFFF_FFFF);
        check("dz_hi", rsp_hi, 9);
`endif
        finish_rsp();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
